issue_ex_ctrl: RTL and testbench



---
 rtl/issue_ex_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 tb/tb_issue_ex_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/issue_ex_ctrl.sv
// ----------------------------------------------------------------------------
// issue_ex_ctrl
//
// Issue-to-execute control stage that sits directly after the reservation
// station (RS). It accepts at most one issued instruction per cycle and tracks
// it through one of three execution units:
//   - ALU : single cycle
//   - MUL : MULT_LAT cycles (iterative, one at a time)
//   - MEM : MEM_LAT cycles, shared by LOAD and STORE
// Finished units are arbitrated onto the single CDB with fixed priority
// MUL > MEM > ALU. The granted unit also frees its RS entry through
// remove_en_o/remove_idx_o.
//
// Optional build macro:
//   PIPELINED_MULT_EN - the multiplier becomes a MULT_LAT-deep shift pipeline
//                       that accepts one instruction per cycle.
//
// Ports:
//   clock_i            system clock
//   reset_ni           asynchronous active-low reset
//   flush_i            synchronous squash of all in-flight work
//   issue_en_i         RS presents a valid issued instruction
//   issue_class_i      0=ALU, 1=MUL, 2=LOAD, 3=STORE
//   issue_rs_idx_i     RS entry index of the issued instruction
//   issue_dest_tag_i   destination physical register tag
//   issue_dest_valid_i instruction writes a register
//   issue_ready_o      unit selected by issue_class_i can accept this cycle
//   cdb_en_o           CDB broadcast valid
//   cdb_tag_o          CDB broadcast tag
//   remove_en_o        free an RS entry
//   remove_idx_o       RS entry to free
//   mul_busy_o         multiplier holds in-flight work
// ----------------------------------------------------------------------------
module issue_ex_ctrl #(
    parameter int unsigned RS_SZ    = 5,
    parameter int unsigned TAG_W    = 6,
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned MEM_LAT  = 2,
    localparam int unsigned RS_IDX_W = (RS_SZ > 1) ? $clog2(RS_SZ) : 1
) (
    input  logic                clock_i,
    input  logic                reset_ni,
    input  logic                flush_i,
    input  logic                issue_en_i,
    input  logic [1:0]          issue_class_i,
    input  logic [RS_IDX_W-1:0] issue_rs_idx_i,
    input  logic [TAG_W-1:0]    issue_dest_tag_i,
    input  logic                issue_dest_valid_i,
    output logic                issue_ready_o,
    output logic                cdb_en_o,
    output logic [TAG_W-1:0]    cdb_tag_o,
    output logic                remove_en_o,
    output logic [RS_IDX_W-1:0] remove_idx_o,
    output logic                mul_busy_o
);

    localparam int unsigned MUL_CNT_W = $clog2(MULT_LAT + 1);
    localparam int unsigned MEM_CNT_W = $clog2(MEM_LAT + 1);

    localparam logic [MUL_CNT_W-1:0] MulLoad = MUL_CNT_W'(MULT_LAT - 1);
    localparam logic [MEM_CNT_W-1:0] MemLoad = MEM_CNT_W'(MEM_LAT - 1);

    localparam logic [1:0] ClsAlu   = 2'd0;
    localparam logic [1:0] ClsMul   = 2'd1;
    localparam logic [1:0] ClsLoad  = 2'd2;
    localparam logic [1:0] ClsStore = 2'd3;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} unit_st_e;

    // ------------------------------------------------------------------------
    // Shared control signals
    // ------------------------------------------------------------------------
    logic grant_alu, grant_mem, grant_mul;
    logic acc_alu, acc_mem, acc_mul;

    // Views of the multiplier that do not depend on its implementation
    logic                mul_done;
    logic                mul_can_accept;
    logic [RS_IDX_W-1:0] mul_done_idx;
    logic [TAG_W-1:0]    mul_done_tag;
    logic                mul_done_dv;

    // A flush cycle drops any issue, so accepts are masked here once
    always_comb begin
        acc_alu = 1'b0;
        acc_mem = 1'b0;
        acc_mul = 1'b0;
        if (issue_en_i && issue_ready_o && !flush_i) begin
            unique case (issue_class_i)
                ClsAlu:           acc_alu = 1'b1;
                ClsMul:           acc_mul = 1'b1;
                ClsLoad, ClsStore: acc_mem = 1'b1;
                default:          ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // ALU unit
    // ------------------------------------------------------------------------
    unit_st_e            alu_st_q, alu_st_d;
    logic [RS_IDX_W-1:0] alu_idx_q, alu_idx_d;
    logic [TAG_W-1:0]    alu_tag_q, alu_tag_d;
    logic                alu_dv_q, alu_dv_d;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            alu_st_q  <= StIdle;
            alu_idx_q <= '0;
            alu_tag_q <= '0;
            alu_dv_q  <= 1'b0;
        end else begin
            alu_st_q  <= alu_st_d;
            alu_idx_q <= alu_idx_d;
            alu_tag_q <= alu_tag_d;
            alu_dv_q  <= alu_dv_d;
        end
    end

    always_comb begin
        alu_st_d  = alu_st_q;
        alu_idx_d = alu_idx_q;
        alu_tag_d = alu_tag_q;
        alu_dv_d  = alu_dv_q;
        if (flush_i) begin
            alu_st_d = StIdle;
        end else if (acc_alu) begin
            // Also covers DONE-and-granted: the new instruction wins
            alu_st_d  = StDone;
            alu_idx_d = issue_rs_idx_i;
            alu_tag_d = issue_dest_tag_i;
            alu_dv_d  = issue_dest_valid_i;
        end else if (grant_alu) begin
            alu_st_d = StIdle;
        end
    end

    // ------------------------------------------------------------------------
    // MEM unit (LOAD and STORE)
    // ------------------------------------------------------------------------
    unit_st_e             mem_st_q, mem_st_d;
    logic [MEM_CNT_W-1:0] mem_cnt_q, mem_cnt_d;
    logic [RS_IDX_W-1:0]  mem_idx_q, mem_idx_d;
    logic [TAG_W-1:0]     mem_tag_q, mem_tag_d;
    logic                 mem_dv_q, mem_dv_d;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            mem_st_q  <= StIdle;
            mem_cnt_q <= '0;
            mem_idx_q <= '0;
            mem_tag_q <= '0;
            mem_dv_q  <= 1'b0;
        end else begin
            mem_st_q  <= mem_st_d;
            mem_cnt_q <= mem_cnt_d;
            mem_idx_q <= mem_idx_d;
            mem_tag_q <= mem_tag_d;
            mem_dv_q  <= mem_dv_d;
        end
    end

    always_comb begin
        mem_st_d  = mem_st_q;
        mem_cnt_d = mem_cnt_q;
        mem_idx_d = mem_idx_q;
        mem_tag_d = mem_tag_q;
        mem_dv_d  = mem_dv_q;
        if (flush_i) begin
            mem_st_d  = StIdle;
            mem_cnt_d = '0;
        end else if (acc_mem) begin
            mem_idx_d = issue_rs_idx_i;
            mem_tag_d = issue_dest_tag_i;
            mem_dv_d  = issue_dest_valid_i;
            if (MEM_LAT == 1) begin
                mem_st_d  = StDone;
                mem_cnt_d = '0;
            end else begin
                mem_st_d  = StBusy;
                mem_cnt_d = MemLoad;
            end
        end else begin
            unique case (mem_st_q)
                StBusy: begin
                    mem_cnt_d = mem_cnt_q - MEM_CNT_W'(1);
                    if (mem_cnt_q == MEM_CNT_W'(1)) begin
                        mem_st_d = StDone;
                    end
                end
                StDone: begin
                    if (grant_mem) begin
                        mem_st_d = StIdle;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // MUL unit
    // ------------------------------------------------------------------------
`ifdef PIPELINED_MULT_EN
    // Stage MULT_LAT-1 is the DONE stage; the whole pipe stalls while it
    // holds an ungranted result.
    logic [MULT_LAT-1:0] mul_v_q, mul_v_d;
    logic [RS_IDX_W-1:0] mul_idx_q [MULT_LAT];
    logic [RS_IDX_W-1:0] mul_idx_d [MULT_LAT];
    logic [TAG_W-1:0]    mul_tag_q [MULT_LAT];
    logic [TAG_W-1:0]    mul_tag_d [MULT_LAT];
    logic [MULT_LAT-1:0] mul_dv_q, mul_dv_d;
    logic                mul_advance;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            mul_v_q  <= '0;
            mul_dv_q <= '0;
            for (int i = 0; i < MULT_LAT; i++) begin
                mul_idx_q[i] <= '0;
                mul_tag_q[i] <= '0;
            end
        end else begin
            mul_v_q  <= mul_v_d;
            mul_dv_q <= mul_dv_d;
            for (int i = 0; i < MULT_LAT; i++) begin
                mul_idx_q[i] <= mul_idx_d[i];
                mul_tag_q[i] <= mul_tag_d[i];
            end
        end
    end

    always_comb begin
        mul_done       = mul_v_q[MULT_LAT-1];
        mul_done_idx   = mul_idx_q[MULT_LAT-1];
        mul_done_tag   = mul_tag_q[MULT_LAT-1];
        mul_done_dv    = mul_dv_q[MULT_LAT-1];
        mul_advance    = !mul_v_q[MULT_LAT-1] || grant_mul;
        mul_can_accept = !mul_v_q[0] || mul_advance;
        mul_busy_o     = |mul_v_q;
    end

    always_comb begin
        mul_v_d  = mul_v_q;
        mul_dv_d = mul_dv_q;
        for (int i = 0; i < MULT_LAT; i++) begin
            mul_idx_d[i] = mul_idx_q[i];
            mul_tag_d[i] = mul_tag_q[i];
        end
        if (flush_i) begin
            mul_v_d = '0;
        end else begin
            if (mul_advance) begin
                for (int i = MULT_LAT - 1; i > 0; i--) begin
                    mul_v_d[i]   = mul_v_q[i-1];
                    mul_dv_d[i]  = mul_dv_q[i-1];
                    mul_idx_d[i] = mul_idx_q[i-1];
                    mul_tag_d[i] = mul_tag_q[i-1];
                end
                mul_v_d[0] = 1'b0;
            end
            // When stalled, an accept only happens into an empty stage 0
            if (acc_mul) begin
                mul_v_d[0]   = 1'b1;
                mul_dv_d[0]  = issue_dest_valid_i;
                mul_idx_d[0] = issue_rs_idx_i;
                mul_tag_d[0] = issue_dest_tag_i;
            end
        end
    end
`else
    unit_st_e             mul_st_q, mul_st_d;
    logic [MUL_CNT_W-1:0] mul_cnt_q, mul_cnt_d;
    logic [RS_IDX_W-1:0]  mul_idx_q, mul_idx_d;
    logic [TAG_W-1:0]     mul_tag_q, mul_tag_d;
    logic                 mul_dv_q, mul_dv_d;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            mul_st_q  <= StIdle;
            mul_cnt_q <= '0;
            mul_idx_q <= '0;
            mul_tag_q <= '0;
            mul_dv_q  <= 1'b0;
        end else begin
            mul_st_q  <= mul_st_d;
            mul_cnt_q <= mul_cnt_d;
            mul_idx_q <= mul_idx_d;
            mul_tag_q <= mul_tag_d;
            mul_dv_q  <= mul_dv_d;
        end
    end

    always_comb begin
        mul_done       = (mul_st_q == StDone);
        mul_done_idx   = mul_idx_q;
        mul_done_tag   = mul_tag_q;
        mul_done_dv    = mul_dv_q;
        mul_can_accept = (mul_st_q == StIdle) || ((mul_st_q == StDone) && grant_mul);
        mul_busy_o     = (mul_st_q != StIdle);
    end

    always_comb begin
        mul_st_d  = mul_st_q;
        mul_cnt_d = mul_cnt_q;
        mul_idx_d = mul_idx_q;
        mul_tag_d = mul_tag_q;
        mul_dv_d  = mul_dv_q;
        if (flush_i) begin
            mul_st_d  = StIdle;
            mul_cnt_d = '0;
        end else if (acc_mul) begin
            mul_st_d  = StBusy;
            mul_cnt_d = MulLoad;
            mul_idx_d = issue_rs_idx_i;
            mul_tag_d = issue_dest_tag_i;
            mul_dv_d  = issue_dest_valid_i;
        end else begin
            unique case (mul_st_q)
                StBusy: begin
                    mul_cnt_d = mul_cnt_q - MUL_CNT_W'(1);
                    if (mul_cnt_q == MUL_CNT_W'(1)) begin
                        mul_st_d = StDone;
                    end
                end
                StDone: begin
                    if (grant_mul) begin
                        mul_st_d = StIdle;
                    end
                end
                default: ;
            endcase
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Completion arbiter and issue_ready (combinational outputs)
    // ------------------------------------------------------------------------
    always_comb begin
        grant_mul = mul_done;
        grant_mem = (mem_st_q == StDone) && !mul_done;
        grant_alu = (alu_st_q == StDone) && !mul_done && (mem_st_q != StDone);

        remove_en_o  = 1'b0;
        remove_idx_o = '0;
        cdb_tag_o    = '0;
        cdb_en_o     = 1'b0;
        if (grant_mul) begin
            remove_en_o  = 1'b1;
            remove_idx_o = mul_done_idx;
            cdb_tag_o    = mul_done_tag;
            cdb_en_o     = mul_done_dv;
        end else if (grant_mem) begin
            remove_en_o  = 1'b1;
            remove_idx_o = mem_idx_q;
            cdb_tag_o    = mem_tag_q;
            cdb_en_o     = mem_dv_q;
        end else if (grant_alu) begin
            remove_en_o  = 1'b1;
            remove_idx_o = alu_idx_q;
            cdb_tag_o    = alu_tag_q;
            cdb_en_o     = alu_dv_q;
        end
    end

    // Depends only on unit state and grants, never on issue_en_i
    always_comb begin
        issue_ready_o = 1'b0;
        unique case (issue_class_i)
            ClsAlu:            issue_ready_o = (alu_st_q == StIdle) || grant_alu;
            ClsMul:            issue_ready_o = mul_can_accept;
            ClsLoad, ClsStore: issue_ready_o = (mem_st_q == StIdle) || grant_mem;
            default:           ;
        endcase
    end

endmodule

// File: tb/tb_issue_ex_ctrl.sv
// ----------------------------------------------------------------------------
// tb_issue_ex_ctrl
//
// Directed bench for issue_ex_ctrl with default parameters (RS_SZ=5, TAG_W=6,
// MULT_LAT=4, MEM_LAT=2). Inputs change 2 time units after a rising edge and
// outputs are checked 1 unit later, mid-cycle. "cN" below is the cycle count
// relative to the issue cycle of each scenario.
// ----------------------------------------------------------------------------
module tb_issue_ex_ctrl;

    logic       clock;
    logic       reset_n;
    logic       flush;
    logic       issue_en;
    logic [1:0] issue_class;
    logic [2:0] issue_rs_idx;
    logic [5:0] issue_dest_tag;
    logic       issue_dest_valid;
    logic       issue_ready;
    logic       cdb_en;
    logic [5:0] cdb_tag;
    logic       remove_en;
    logic [2:0] remove_idx;
    logic       mul_busy;

    int checks   = 0;
    int failures = 0;

    issue_ex_ctrl dut (
        .clock_i            (clock),
        .reset_ni           (reset_n),
        .flush_i            (flush),
        .issue_en_i         (issue_en),
        .issue_class_i      (issue_class),
        .issue_rs_idx_i     (issue_rs_idx),
        .issue_dest_tag_i   (issue_dest_tag),
        .issue_dest_valid_i (issue_dest_valid),
        .issue_ready_o      (issue_ready),
        .cdb_en_o           (cdb_en),
        .cdb_tag_o          (cdb_tag),
        .remove_en_o        (remove_en),
        .remove_idx_o       (remove_idx),
        .mul_busy_o         (mul_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic drive(input logic en, input logic [1:0] cls, input logic [2:0] idx,
                         input logic [5:0] tag, input logic dv);
        issue_en         = en;
        issue_class      = cls;
        issue_rs_idx     = idx;
        issue_dest_tag   = tag;
        issue_dest_valid = dv;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 3'd0, 6'd0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        flush   = 1'b0;
        idle();
        #3;
        chk("rst_cdb_en", 32'(cdb_en), 32'd0);
        chk("rst_remove_en", 32'(remove_en), 32'd0);
        chk("rst_cdb_tag", 32'(cdb_tag), 32'd0);
        chk("rst_remove_idx", 32'(remove_idx), 32'd0);
        chk("rst_mul_busy", 32'(mul_busy), 32'd0);
        chk("rst_issue_ready", 32'(issue_ready), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;

        // ALU: issue c0, complete c1
        tick(); drive(1'b1, 2'd0, 3'd3, 6'd12, 1'b1);
        chk("alu_ready_c0", 32'(issue_ready), 32'd1);
        tick(); idle();
        chk("alu_cdb_en_c1", 32'(cdb_en), 32'd1);
        chk("alu_cdb_tag_c1", 32'(cdb_tag), 32'd12);
        chk("alu_remove_en_c1", 32'(remove_en), 32'd1);
        chk("alu_remove_idx_c1", 32'(remove_idx), 32'd3);
        tick(); idle();
        chk("alu_cdb_en_c2", 32'(cdb_en), 32'd0);
        chk("alu_remove_en_c2", 32'(remove_en), 32'd0);
        chk("alu_cdb_tag_c2", 32'(cdb_tag), 32'd0);

`ifndef PIPELINED_MULT_EN
        // MUL: issue c0, done c4; a second MUL in c1 is refused
        tick(); drive(1'b1, 2'd1, 3'd0, 6'd20, 1'b1);
        chk("mul_ready_c0", 32'(issue_ready), 32'd1);
        tick(); drive(1'b1, 2'd1, 3'd1, 6'd21, 1'b1);
        chk("mul2_ready_c1", 32'(issue_ready), 32'd0);
        chk("mul_busy_c1", 32'(mul_busy), 32'd1);
        tick(); idle();
        chk("mul_busy_c2", 32'(mul_busy), 32'd1);
        chk("mul_cdb_en_c2", 32'(cdb_en), 32'd0);
        tick(); idle();
        chk("mul_busy_c3", 32'(mul_busy), 32'd1);
        chk("mul_remove_en_c3", 32'(remove_en), 32'd0);
        tick(); idle();
        chk("mul_busy_c4", 32'(mul_busy), 32'd1);
        chk("mul_cdb_en_c4", 32'(cdb_en), 32'd1);
        chk("mul_cdb_tag_c4", 32'(cdb_tag), 32'd20);
        chk("mul_remove_idx_c4", 32'(remove_idx), 32'd0);
        tick(); idle();
        chk("mul_busy_c5", 32'(mul_busy), 32'd0);
        chk("mul_remove_en_c5", 32'(remove_en), 32'd0);
`endif

        // MUL done c4 beats ALU issued c3; ALU held to c5
        tick(); drive(1'b1, 2'd1, 3'd1, 6'd30, 1'b1);
        tick(); idle();
        tick(); idle();
        tick(); drive(1'b1, 2'd0, 3'd4, 6'd7, 1'b1);
        chk("prio_alu_ready_c3", 32'(issue_ready), 32'd1);
        tick(); idle();
        chk("prio_cdb_tag_c4", 32'(cdb_tag), 32'd30);
        chk("prio_remove_idx_c4", 32'(remove_idx), 32'd1);
        chk("prio_alu_ready_c4", 32'(issue_ready), 32'd0);
        tick(); idle();
        chk("prio_cdb_en_c5", 32'(cdb_en), 32'd1);
        chk("prio_cdb_tag_c5", 32'(cdb_tag), 32'd7);
        chk("prio_remove_idx_c5", 32'(remove_idx), 32'd4);
        chk("prio_alu_ready_c5", 32'(issue_ready), 32'd1);
        tick(); idle();
        chk("prio_remove_en_c6", 32'(remove_en), 32'd0);

        // LOAD c0 and ALU c1 both done c2: MEM wins, ALU follows c3
        tick(); drive(1'b1, 2'd2, 3'd1, 6'd15, 1'b1);
        tick(); drive(1'b1, 2'd0, 3'd4, 6'd33, 1'b1);
        tick(); idle();
        chk("ld_cdb_tag_c2", 32'(cdb_tag), 32'd15);
        chk("ld_remove_idx_c2", 32'(remove_idx), 32'd1);
        chk("ld_alu_ready_c2", 32'(issue_ready), 32'd0);
        tick(); idle();
        chk("ld_alu_cdb_tag_c3", 32'(cdb_tag), 32'd33);
        chk("ld_alu_remove_idx_c3", 32'(remove_idx), 32'd4);

        // STORE frees RS entry without a broadcast
        tick(); drive(1'b1, 2'd3, 3'd2, 6'd9, 1'b0);
        tick(); drive(1'b0, 2'd3, 3'd0, 6'd0, 1'b0);
        chk("st_mem_ready_c1", 32'(issue_ready), 32'd0);
        chk("st_remove_en_c1", 32'(remove_en), 32'd0);
        tick(); idle();
        chk("st_remove_en_c2", 32'(remove_en), 32'd1);
        chk("st_remove_idx_c2", 32'(remove_idx), 32'd2);
        chk("st_cdb_en_c2", 32'(cdb_en), 32'd0);
        tick(); idle();
        chk("st_remove_en_c3", 32'(remove_en), 32'd0);

        // Flush in c2 kills the MUL and drops an ALU issued alongside it
        tick(); drive(1'b1, 2'd1, 3'd0, 6'd20, 1'b1);
        tick(); idle();
        tick(); flush = 1'b1; drive(1'b1, 2'd0, 3'd1, 6'd44, 1'b1);
        chk("fl_mul_busy_c2", 32'(mul_busy), 32'd1);
        tick(); flush = 1'b0; drive(1'b1, 2'd0, 3'd3, 6'd5, 1'b1);
        chk("fl_mul_busy_c3", 32'(mul_busy), 32'd0);
        chk("fl_remove_en_c3", 32'(remove_en), 32'd0);
        chk("fl_cdb_en_c3", 32'(cdb_en), 32'd0);
        tick(); idle();
        chk("fl_cdb_tag_c4", 32'(cdb_tag), 32'd5);
        chk("fl_remove_idx_c4", 32'(remove_idx), 32'd3);
        tick(); idle();
        chk("fl_remove_en_c5", 32'(remove_en), 32'd0);
        chk("fl_mul_busy_c5", 32'(mul_busy), 32'd0);

        // Asynchronous reset mid-operation
        tick(); drive(1'b1, 2'd1, 3'd2, 6'd40, 1'b1);
        tick(); idle();
        chk("ar_mul_busy_before", 32'(mul_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("ar_mul_busy_now", 32'(mul_busy), 32'd0);
        chk("ar_issue_ready_now", 32'(issue_ready), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); idle();
            chk("ar_remove_en_after", 32'(remove_en), 32'd0);
        end

`ifdef PIPELINED_MULT_EN
        // Back-to-back MULs broadcast c4..c6; ALU done c5 waits until c7
        tick(); drive(1'b1, 2'd1, 3'd0, 6'd1, 1'b1);
        tick(); drive(1'b1, 2'd1, 3'd1, 6'd2, 1'b1);
        chk("pm_ready_c1", 32'(issue_ready), 32'd1);
        tick(); drive(1'b1, 2'd1, 3'd2, 6'd3, 1'b1);
        tick(); idle();
        tick(); drive(1'b1, 2'd0, 3'd4, 6'd8, 1'b1);
        chk("pm_cdb_tag_c4", 32'(cdb_tag), 32'd1);
        chk("pm_remove_idx_c4", 32'(remove_idx), 32'd0);
        tick(); idle();
        chk("pm_cdb_tag_c5", 32'(cdb_tag), 32'd2);
        chk("pm_alu_ready_c5", 32'(issue_ready), 32'd0);
        tick(); idle();
        chk("pm_cdb_tag_c6", 32'(cdb_tag), 32'd3);
        chk("pm_remove_idx_c6", 32'(remove_idx), 32'd2);
        tick(); idle();
        chk("pm_cdb_tag_c7", 32'(cdb_tag), 32'd8);
        chk("pm_remove_idx_c7", 32'(remove_idx), 32'd4);
        chk("pm_mul_busy_c7", 32'(mul_busy), 32'd0);
        tick(); idle();
        chk("pm_remove_en_c8", 32'(remove_en), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
